rv32_fetch_unit: RTL

- Parametrised instruction fetch front-end for the rv32 core.
- Replaces the free-running PC+4 counter with:
  - a fetch PC register,
  - a valid/ready request port to instruction memory with bounded outstanding requests,
  - an in-order response path,
  - an instruction queue feeding decode over valid/ready.
- Supports redirect from branch/jump resolution by flushing the queue and discarding stale in-flight responses.

---
 rtl/rv32_fetch_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rv32_fetch_unit.sv
// Instruction fetch front-end: fetch PC, credit-limited imem request port,
// in-order response path with stale-response discard, and a decode-side queue.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] pc
);

    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QAW = $clog2(QUEUE_DEPTH);
    localparam int FAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [FAW-1:0] FL_LAST = FAW'(MAX_OUTSTANDING - 1);

    logic [31:0]    r_pc;
    logic [31:0]    r_q_instr [QUEUE_DEPTH];
    logic [31:0]    r_q_pc    [QUEUE_DEPTH];
    logic [QAW-1:0] r_q_wr;
    logic [QAW-1:0] r_q_rd;
    logic [CW-1:0]  r_q_count;
    logic [31:0]    r_fl_pc   [MAX_OUTSTANDING];
    logic [FAW-1:0] r_fl_wr;
    logic [FAW-1:0] r_fl_rd;
    logic [OW-1:0]  r_outstanding;
    logic [OW-1:0]  r_discard_cnt;

    logic           w_credit_ok;
    logic           w_req_valid;
    logic           w_req_fire;
    logic           w_resp_take;
    logic           w_push;
    logic           w_out_valid;
    logic           w_pop;
    logic [31:0]    w_resp_pc;
    logic [31:0]    w_redirect_target;
    logic [OW-1:0]  w_outstanding_next;

    function automatic logic [FAW-1:0] fl_next(input logic [FAW-1:0] p);
        return (p == FL_LAST) ? '0 : p + FAW'(1);
    endfunction

    // Credits cover both queued entries and requests still in flight, so every
    // response that comes back (stale or not) is guaranteed a queue slot.
    assign w_credit_ok = (32'(r_outstanding) < 32'(MAX_OUTSTANDING)) &&
                         ((32'(r_outstanding) + 32'(r_q_count)) < 32'(QUEUE_DEPTH));
    assign w_req_valid = !reset && !redirect_valid && w_credit_ok;
    assign w_req_fire  = w_req_valid && imem_req_ready;

    assign w_resp_take = imem_resp_valid && (r_outstanding != '0);
    assign w_push      = w_resp_take && (r_discard_cnt == '0) && !redirect_valid;
    assign w_resp_pc   = r_fl_pc[r_fl_rd];

    assign w_out_valid = (r_q_count != '0) && !redirect_valid;
    assign w_pop       = w_out_valid && out_ready;

    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_req_fire) begin
            w_outstanding_next = w_outstanding_next + OW'(1);
        end
        if (w_resp_take) begin
            w_outstanding_next = w_outstanding_next - OW'(1);
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign out_valid      = w_out_valid;
    assign out_instr      = r_q_instr[r_q_rd];
    assign out_pc         = r_q_pc[r_q_rd];
    assign pc             = r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_req_fire) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Redirect turns every request still in flight into one to be dropped,
    // including accounting for a response that lands in the redirect cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
            r_discard_cnt <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_discard_cnt <= w_outstanding_next;
            end else if (w_resp_take && (r_discard_cnt != '0)) begin
                r_discard_cnt <= r_discard_cnt - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fl_wr <= '0;
            r_fl_rd <= '0;
        end else begin
            if (w_req_fire) begin
                r_fl_wr <= fl_next(r_fl_wr);
            end
            if (w_resp_take) begin
                r_fl_rd <= fl_next(r_fl_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_fl_pc[r_fl_wr] <= r_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q_wr    <= '0;
            r_q_rd    <= '0;
            r_q_count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            r_q_wr    <= '0;
            r_q_rd    <= '0;
            r_q_count <= '0;
        end else begin
            if (w_push) begin
                r_q_instr[r_q_wr] <= imem_resp_data;
                r_q_pc[r_q_wr]    <= w_resp_pc;
                r_q_wr            <= r_q_wr + QAW'(1);
            end
            if (w_pop) begin
                r_q_rd <= r_q_rd + QAW'(1);
            end
            r_q_count <= r_q_count + CW'(w_push) - CW'(w_pop);
        end
    end

    a_resp_has_credit: assert property (
        @(posedge clk) disable iff (reset) imem_resp_valid |-> (r_outstanding != '0)
    );

endmodule
